writeback_regfile: RTL and testbench
====================================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- RegWriteW  in  1  writeback enable from the MEM/WB register.
- ResultSrcW  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
- ALUResultW, ReadDataW, PCPlus4W  in  32 each  writeback candidates.
- RdW  in  5  destination register index.
- ValidW  in  1  high when the W stage holds a real instruction, low for a bubble.
- Rs1D, Rs2D  in  5 each  decode-stage read addresses.
- RD1D, RD2D  out  32 each  decode-stage read data.
- ResultW  out  32  selected writeback value, also used for forwarding.
- InstRetW  out  64  count of retired instructions.
REQ-002 There SHALL be no parameters; XLEN 32 and 32 registers are fixed.

Function
REQ-003 ResultW SHALL be combinational: 00 ALUResultW; 01 ReadDataW; 10 PCPlus4W; 11 ALUResultW.
REQ-004 A write SHALL occur on the rising edge of clk when RegWriteW=1, ValidW=1 and RdW!=0: reg[RdW] <= ResultW.
REQ-005 A write to x0 SHALL be discarded; RD1D/RD2D SHALL read 0 for address 0 at all times.
REQ-006 Reads SHALL be combinational; RD1D=reg[Rs1D] and RD2D=reg[Rs2D].
REQ-007 When RegWriteW=0 or ValidW=0, the register contents SHALL hold.
REQ-008 InstRetW SHALL increment by 1 on each rising edge with ValidW=1, regardless of RegWriteW.
REQ-009 InstRetW SHALL wrap from 2^64-1 to 0 with no flag.
REQ-010 Both read ports SHALL be able to address the same register as each other or as RdW in the same cycle without conflict.

Reset
REQ-011 Assertion of reset_n=0 SHALL immediately clear x1..x31 and InstRetW to 0, independent of clk.
REQ-012 Assertion of reset_n=0 SHALL cancel any write pending in that cycle.
REQ-013 During reset, RD1D and RD2D SHALL read 0, and ResultW SHALL remain combinational on its inputs.
REQ-014 The first write SHALL take effect on the first rising edge after reset_n deasserts.

Configuration
REQ-015 With WB_BYPASS_EN defined, a read port whose address equals RdW SHALL return ResultW in that cycle when RegWriteW=1, ValidW=1 and RdW!=0 (write-through).
REQ-016 Without WB_BYPASS_EN, read ports SHALL return the stored (pre-write) value, and the hazard unit SHALL stall decode one cycle.

Structure
REQ-017 The shared package SHALL hold the ResultSrc encodings (RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10) and the XLEN and register-count constants.
REQ-018 The storage array SHALL be one sub-module, regfile_core (two async read ports, one sync write port, async clear); the result mux, bypass and counter SHALL live in the top module.

Verification
REQ-019 Select coverage: ResultSrcW=01, ReadDataW=0xDEADBEEF, RdW=5, RegWriteW=1, ValidW=1, one edge -> reg5 reads 0xDEADBEEF; ResultSrcW=10, PCPlus4W=0x104 -> ResultW=0x104.
REQ-020 x0 guard: write 0x12345678 to RdW=0 -> RD1D with Rs1D=0 reads 0.
REQ-021 Same-cycle hazard: reg7=0x11, write 0x22 to RdW=7 with Rs1D=7 -> RD1D=0x22 with WB_BYPASS_EN, 0x11 without; 0x22 after the edge in both builds.
REQ-022 Bubble: ValidW=0, RegWriteW=1, RdW=3, value 0xFF -> reg3 unchanged and InstRetW unchanged.
REQ-023 Async reset mid-operation: write reg9=0xAA, then drop reset_n between clock edges -> reg9=0 and InstRetW=0 before the next edge.
REQ-024 Counter wrap: preload InstRetW to 0xFFFF_FFFF_FFFF_FFFF, then ValidW=1 for one edge -> InstRetW=0.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Shared constants and encodings for the writeback / register file slice.
// Imported by writeback_regfile and regfile_core.
package writeback_regfile_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int CNTW  = 64;

   typedef enum logic [1:0] {
      RESULT_ALU  = 2'b00,
      RESULT_MEM  = 2'b01,
      RESULT_PC4  = 2'b10,
      RESULT_RSVD = 2'b11
   } result_src_e;

endpackage

// File: rtl/regfile_core.sv
// 32 x XLEN storage: two async read ports, one sync write port.
// Asynchronous active-low clear; x0 is hardwired to zero.
module regfile_core
   import writeback_regfile_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];

   // next-state: apply the single write, never to x0
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (we && (waddr != '0)) begin
         regs_d[waddr] = wdata;
      end
      regs_d[0] = '0;
   end

   // storage flops, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // combinational reads, address 0 forced to zero
   always_comb begin
      rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
      rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
   end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result mux, register file, retire counter.
// Define WB_BYPASS_EN for write-through on read/write address match.
module writeback_regfile
   import writeback_regfile_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            RegWriteW,
   input  logic [1:0]      ResultSrcW,
   input  logic [XLEN-1:0] ALUResultW,
   input  logic [XLEN-1:0] ReadDataW,
   input  logic [XLEN-1:0] PCPlus4W,
   input  logic [AW-1:0]   RdW,
   input  logic            ValidW,
   input  logic [AW-1:0]   Rs1D,
   input  logic [AW-1:0]   Rs2D,
   output logic [XLEN-1:0] RD1D,
   output logic [XLEN-1:0] RD2D,
   output logic [XLEN-1:0] ResultW,
   output logic [CNTW-1:0] InstRetW
);

   logic            wr_en;
   logic [XLEN-1:0] core_rd1;
   logic [XLEN-1:0] core_rd2;
   logic [CNTW-1:0] instret_q;
   logic [CNTW-1:0] instret_d;

   // writeback result select; reserved code falls back to ALU
   always_comb begin
      ResultW = ALUResultW;
      unique case (result_src_e'(ResultSrcW))
         RESULT_ALU:  ResultW = ALUResultW;
         RESULT_MEM:  ResultW = ReadDataW;
         RESULT_PC4:  ResultW = PCPlus4W;
         RESULT_RSVD: ResultW = ALUResultW;
      endcase
   end

   assign wr_en = RegWriteW & ValidW & (RdW != '0);

   regfile_core u_core (
      .clk    (clk),
      .reset_n(reset_n),
      .we     (wr_en),
      .waddr  (RdW),
      .wdata  (ResultW),
      .raddr1 (Rs1D),
      .raddr2 (Rs2D),
      .rdata1 (core_rd1),
      .rdata2 (core_rd2)
   );

`ifdef WB_BYPASS_EN
   // write-through: a matching read sees this cycle's result
   always_comb begin
      RD1D = core_rd1;
      RD2D = core_rd2;
      if (reset_n && wr_en && (Rs1D == RdW)) begin
         RD1D = ResultW;
      end
      if (reset_n && wr_en && (Rs2D == RdW)) begin
         RD2D = ResultW;
      end
   end
`else
   // reads return the stored, pre-write value
   always_comb begin
      RD1D = core_rd1;
      RD2D = core_rd2;
   end
`endif

   // retire counter: count every valid W-stage instruction
   always_comb begin
      instret_d = instret_q;
      if (ValidW) begin
         instret_d = instret_q + 64'd1;
      end
   end

   // retire counter register, wraps silently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instret_q <= '0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign InstRetW = instret_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile against a
// behavioural register-file / retire-count model.
module tb_writeback_regfile;

   logic        clk;
   logic        reset_n;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW;
   logic [31:0] ReadDataW;
   logic [31:0] PCPlus4W;
   logic [4:0]  RdW;
   logic        ValidW;
   logic [4:0]  Rs1D;
   logic [4:0]  Rs2D;
   logic [31:0] RD1D;
   logic [31:0] RD2D;
   logic [31:0] ResultW;
   logic [63:0] InstRetW;

   int pass_cnt;
   int total_cnt;

   logic [31:0] mdl [32];
   logic [63:0] mdl_cnt;

   writeback_regfile dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .RegWriteW (RegWriteW),
      .ResultSrcW(ResultSrcW),
      .ALUResultW(ALUResultW),
      .ReadDataW (ReadDataW),
      .PCPlus4W  (PCPlus4W),
      .RdW       (RdW),
      .ValidW    (ValidW),
      .Rs1D      (Rs1D),
      .Rs2D      (Rs2D),
      .RD1D      (RD1D),
      .RD2D      (RD2D),
      .ResultW   (ResultW),
      .InstRetW  (InstRetW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_result();
      case (ResultSrcW)
         2'b01:   return ReadDataW;
         2'b10:   return PCPlus4W;
         default: return ALUResultW;
      endcase
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
      if (RegWriteW && ValidW && RdW != 0 && a == RdW)
         return exp_result();
`endif
      return mdl[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      mdl_cnt = 64'd0;
   endtask

   // one rising edge; model updated from inputs seen at the edge
   task automatic step();
      logic [31:0] r;
      r = exp_result();
      @(posedge clk);
      if (RegWriteW && ValidW && RdW != 5'd0) mdl[RdW] = r;
      if (ValidW) mdl_cnt = mdl_cnt + 64'd1;
      #1;
   endtask

   task automatic idle_inputs();
      RegWriteW  = 1'b0;
      ValidW     = 1'b0;
      ResultSrcW = 2'b00;
      ALUResultW = 32'd0;
      ReadDataW  = 32'd0;
      PCPlus4W   = 32'd0;
      RdW        = 5'd0;
   endtask

   task automatic wr(input logic [4:0] rd,
                     input logic [31:0] v);
      RegWriteW  = 1'b1;
      ValidW     = 1'b1;
      ResultSrcW = 2'b00;
      ALUResultW = v;
      RdW        = rd;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle_inputs();
      Rs1D = 5'd0;
      Rs2D = 5'd0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      Rs1D = 5'd1;
      Rs2D = 5'd31;
      wr(5'd1, 32'h55);
      #1;
      total_cnt++;
      if (RD1D !== 32'd0 || RD2D !== 32'd0)
         $display("FAIL reset_read rd1=%h rd2=%h exp 0",
                  RD1D, RD2D);
      else pass_cnt++;
      total_cnt++;
      if (InstRetW !== 64'd0)
         $display("FAIL reset_cnt got %h exp 0", InstRetW);
      else pass_cnt++;
      total_cnt++;
      if (ResultW !== 32'h55)
         $display("FAIL reset_result got %h exp 55", ResultW);
      else pass_cnt++;
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_select();
      wr(5'd5, 32'h0);
      ResultSrcW = 2'b01;
      ReadDataW  = 32'hDEADBEEF;
      #1;
      total_cnt++;
      if (ResultW !== 32'hDEADBEEF)
         $display("FAIL sel_mem got %h exp deadbeef", ResultW);
      else pass_cnt++;
      step();
      idle_inputs();
      Rs1D = 5'd5;
      #1;
      total_cnt++;
      if (RD1D !== 32'hDEADBEEF)
         $display("FAIL reg5 got %h exp deadbeef", RD1D);
      else pass_cnt++;
      ResultSrcW = 2'b10;
      PCPlus4W   = 32'h104;
      ALUResultW = 32'h9;
      #1;
      total_cnt++;
      if (ResultW !== 32'h104)
         $display("FAIL sel_pc4 got %h exp 104", ResultW);
      else pass_cnt++;
      ResultSrcW = 2'b11;
      #1;
      total_cnt++;
      if (ResultW !== 32'h9)
         $display("FAIL sel_rsvd got %h exp 9", ResultW);
      else pass_cnt++;
      idle_inputs();
   endtask

   task automatic test_x0();
      wr(5'd0, 32'h12345678);
      step();
      idle_inputs();
      Rs1D = 5'd0;
      Rs2D = 5'd0;
      #1;
      total_cnt++;
      if (RD1D !== 32'd0 || RD2D !== 32'd0)
         $display("FAIL x0 rd1=%h rd2=%h exp 0", RD1D, RD2D);
      else pass_cnt++;
   endtask

   task automatic test_hazard();
      logic [31:0] e;
      wr(5'd7, 32'h11);
      step();
      wr(5'd7, 32'h22);
      Rs1D = 5'd7;
      Rs2D = 5'd7;
      #1;
`ifdef WB_BYPASS_EN
      e = 32'h22;
`else
      e = 32'h11;
`endif
      total_cnt++;
      if (RD1D !== e || RD2D !== e)
         $display("FAIL hazard_pre rd1=%h rd2=%h exp %h",
                  RD1D, RD2D, e);
      else pass_cnt++;
      step();
      idle_inputs();
      #1;
      total_cnt++;
      if (RD1D !== 32'h22)
         $display("FAIL hazard_post got %h exp 22", RD1D);
      else pass_cnt++;
   endtask

   task automatic test_bubble();
      logic [63:0] c0;
      c0 = mdl_cnt;
      wr(5'd3, 32'hFF);
      ValidW = 1'b0;
      step();
      idle_inputs();
      Rs1D = 5'd3;
      #1;
      total_cnt++;
      if (RD1D !== 32'd0)
         $display("FAIL bubble_reg got %h exp 0", RD1D);
      else pass_cnt++;
      total_cnt++;
      if (InstRetW !== c0)
         $display("FAIL bubble_cnt got %h exp %h", InstRetW, c0);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int n = 0; n < 300; n++) begin
         RegWriteW  = 1'($urandom_range(0, 3) != 0);
         ValidW     = 1'($urandom_range(0, 4) != 0);
         ResultSrcW = 2'($urandom);
         ALUResultW = $urandom;
         ReadDataW  = $urandom;
         PCPlus4W   = $urandom;
         RdW        = 5'($urandom);
         Rs1D       = 5'($urandom);
         Rs2D       = ($urandom_range(0, 3) == 0) ? RdW
                                                  : 5'($urandom);
         #1;
         total_cnt++;
         if (ResultW !== exp_result() ||
             RD1D !== exp_read(Rs1D) ||
             RD2D !== exp_read(Rs2D)) begin
            errs++;
            if (errs < 5)
               $display("FAIL rand_rd n=%0d res=%h rd1=%h rd2=%h exp %h %h %h",
                        n, ResultW, RD1D, RD2D, exp_result(),
                        exp_read(Rs1D), exp_read(Rs2D));
         end else pass_cnt++;
         step();
         total_cnt++;
         if (InstRetW !== mdl_cnt) begin
            errs++;
            if (errs < 5)
               $display("FAIL rand_cnt n=%0d got %h exp %h",
                        n, InstRetW, mdl_cnt);
         end else pass_cnt++;
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      wr(5'd9, 32'hAA);
      step();
      Rs1D = 5'd9;
      Rs2D = 5'd9;
      wr(5'd9, 32'hBB);
      #2;
      reset_n = 1'b0;
      model_clear();
      #1;
      total_cnt++;
      if (RD1D !== 32'd0 || RD2D !== 32'd0)
         $display("FAIL areset_reg rd1=%h rd2=%h exp 0",
                  RD1D, RD2D);
      else pass_cnt++;
      total_cnt++;
      if (InstRetW !== 64'd0)
         $display("FAIL areset_cnt got %h exp 0", InstRetW);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (RD1D !== 32'd0)
         $display("FAIL areset_hold got %h exp 0", RD1D);
      else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      wr(5'd9, 32'h33);
      step();
      idle_inputs();
      #1;
      total_cnt++;
      if (RD1D !== 32'h33 || InstRetW !== mdl_cnt)
         $display("FAIL first_write rd1=%h cnt=%h exp 33 %h",
                  RD1D, InstRetW, mdl_cnt);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      idle_inputs();
      @(negedge clk);
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      mdl_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      total_cnt++;
      if (InstRetW !== mdl_cnt)
         $display("FAIL preload got %h exp %h", InstRetW, mdl_cnt);
      else pass_cnt++;
      ValidW = 1'b1;
      step();
      idle_inputs();
      total_cnt++;
      if (InstRetW !== mdl_cnt || mdl_cnt !== 64'd0)
         $display("FAIL wrap got %h exp 0", InstRetW);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_select();
      test_x0();
      test_hazard();
      test_bubble();
      test_random();
      test_async_reset();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
